i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C target (responder) for the accelerator CPLD's scl/sda pins.
- An external I2C controller (BBC user-port bit-bang or debug host) reads and writes a small bank of configuration/mailbox bytes.
- The block oversamples SCL/SDA with the CPLD system clock and drives SDA open-drain.
- Register outputs feed the map/clock control logic.

Parameters:
- I2C_ADDR, 7'h50, 7-bit target address this block answers to.
- NREGS, 4, number of 8-bit registers. Must be a power of 2, range 2..16.
- PTR_W, 2, log2(NREGS), pointer width.

Ports:
- clk  input  1  system clock (hsclk domain). Must be at least 10x the SCL frequency.
- resetb  input  1  asynchronous, active-low reset.
- scl_in  input  1  raw SCL pin value. Asynchronous.
- sda_in  input  1  raw SDA pin value. Asynchronous.
- sda_oe  output  1  1 pulls SDA low. Top level drives `sda = sda_oe ? 1'b0 : 1'bz`.
- regs_out  output  8*NREGS  register bank, flattened; reg i is at bits [8i+7:8i].
- wr_pulse  output  1  one-clk strobe when a data byte is committed.
- wr_idx  output  PTR_W  index written; valid while wr_pulse=1.
- busy  output  1  high from an addressed START/match until STOP or NACK exit.

Behaviour:
- Reset (async, resetb=0): all regs=0, ptr=0, sda_oe=0, wr_pulse=0, busy=0, state=IDLE, sync flops set to 1.
- Input synchronisers:
  - scl_in and sda_in each pass through a 2-flop synchroniser, then one history flop for edge detect.
  - All decisions use the synchronised values. Latency from pin to action is 3 clk.
- Bus condition detection:
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
  - Both take priority over any state. START always goes to ADDR with bit counter=0 (repeated start included). STOP always goes to IDLE, releases sda_oe, deasserts busy.
- Timing rules:
  - Sample SDA on SCL rising edge.
  - Change sda_oe only on SCL falling edge (clk cycle after detection).
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR:
  - Shift 8 bits MSB first.
  - On the 8th rise, compare [7:1] with I2C_ADDR.
  - Mismatch: go to IGNORE, which waits for START/STOP and never drives SDA.
  - Match: on the next SCL fall set sda_oe=1 (ACK), busy=1.
- ADDR_ACK:
  - On the fall ending the ACK bit, if R/W=0, release SDA and go to PTR.
  - If R/W=1, load shifter with regs[ptr], drive sda_oe=~bit7, go to RDATA.
- PTR:
  - Receive 8 bits; ptr <= byte[PTR_W-1:0] (upper bits ignored).
  - ACK on the following low phase, then go to WDATA.
- WDATA:
  - Receive 8 bits. On the fall after the 8th rise: regs[ptr] <= byte, wr_pulse=1 for one clk, wr_idx=ptr, ptr <= ptr+1 modulo NREGS, assert ACK.
  - Further bytes continue in WDATA.
- RDATA:
  - Shift out on each SCL fall. After the 8th bit, on the fall, release SDA and go to RDATA_ACK.
  - Increment ptr (mod NREGS) at that fall.
- RDATA_ACK: on SCL rise, SDA=0 (controller ACK) means load regs[ptr] on the next fall and continue; SDA=1 (NACK) goes to IGNORE, busy=0.
- Incomplete bytes: a STOP or START arriving mid-byte discards the byte. No register write, no ptr change from the partial byte.
- Read/write collisions: none. Reads and writes are serialised by the protocol. regs_out updates in the same clk as wr_pulse.
- No clock stretching; SCL is never driven.
- Reset asserted mid-transfer: sda_oe drops to 0 immediately (async). Bus recovers at the next START.

Test Plan:
- Write [0xA0, 0x01, 0xA5, 0x3C, STOP]:
  - ACK on all 4 bytes.
  - regs[1]=A5, regs[2]=3C.
  - wr_pulse twice with wr_idx 1 then 2; final ptr=3.
- Wrap: write [0xA0, 0x03, 0x11, 0x22] → regs[3]=11, regs[0]=22 (ptr wraps); wr_idx sequence 3, 0.
- Read with repeated start, regs preset {00:22, 01:A5, 02:3C, 03:11}:
  - Sequence [0xA0, 0x01, Sr, 0xA1], read 3 bytes with ACK, ACK, NACK.
  - SDA returns A5, 3C, 11; sda_oe=0 after NACK; busy=0.
- Wrong address: [0xA2, 0x55, STOP] → sda_oe never asserts; regs unchanged; busy stays 0.
- Abort: [0xA0, 0x00], then STOP after 4 data bits → no wr_pulse, regs[0] unchanged, state IDLE, sda_oe=0.
- Reset mid-read: resetb low while target drives a 0 bit → sda_oe=0 within the same clk, regs=0. Next [0xA0, 0x02, 0x77] transaction → regs[2]=77.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target with a small register bank. SCL/SDA are oversampled on clk and SDA is driven
// open-drain. Registers are addressed by a pointer byte written first; reads auto-increment.
module i2c_target #(
  parameter logic [6:0] I2C_ADDR = 7'h50,
  parameter int         NREGS    = 4,
  parameter int         PTR_W    = 2
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic [8*NREGS-1:0]   regs_out,
  output logic                 wr_pulse,
  output logic [PTR_W-1:0]     wr_idx,
  output logic                 busy,
  output logic [3:0]           state_dbg,
  output logic [PTR_W-1:0]     ptr_dbg
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ADDR_ACK  = 4'd2;
  localparam logic [3:0] PTR       = 4'd3;
  localparam logic [3:0] PTR_ACK   = 4'd4;
  localparam logic [3:0] WDATA     = 4'd5;
  localparam logic [3:0] WDATA_ACK = 4'd6;
  localparam logic [3:0] RDATA     = 4'd7;
  localparam logic [3:0] RDATA_ACK = 4'd8;
  localparam logic [3:0] IGNORE    = 4'd9;

  // [0],[1] synchronise the pin, [2] is the history bit for edge detection
  logic [2:0] scl_pipe_q, scl_pipe_d;
  logic [2:0] sda_pipe_q, sda_pipe_d;

  logic [3:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             rw_q, rw_d;
  logic             wr_pulse_q, wr_pulse_d;
  logic [PTR_W-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]       regs_q [NREGS];
  logic [7:0]       regs_d [NREGS];

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic       rx_rise, rx_fall;
  logic [7:0] rx_byte;

  assign scl_s     = scl_pipe_q[1];
  assign sda_s     = sda_pipe_q[1];
  assign scl_rise  = scl_s & ~scl_pipe_q[2];
  assign scl_fall  = ~scl_s & scl_pipe_q[2];
  assign start_det = scl_s & scl_pipe_q[2] & ~sda_s & sda_pipe_q[2];
  assign stop_det  = scl_s & scl_pipe_q[2] & sda_s & ~sda_pipe_q[2];
  assign rx_rise   = scl_rise && (cnt_q < 4'd8);
  assign rx_fall   = scl_fall && (cnt_q == 4'd8);
  assign rx_byte   = {shift_q[6:0], sda_s};

  always_comb begin
    scl_pipe_d = {scl_pipe_q[1:0], scl_in};
    sda_pipe_d = {sda_pipe_q[1:0], sda_in};
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    wr_pulse_d = 1'b0;
    wr_idx_d   = wr_idx_q;
    regs_d     = regs_q;

    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (rx_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7 && rx_byte[7:1] != I2C_ADDR) begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end else if (rx_fall) begin
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            rw_d     = shift_q[0];
            cnt_d    = 4'd0;
            state_d  = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (!rw_q) begin
              sda_oe_d = 1'b0;
              state_d  = PTR;
            end else begin
              shift_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
              state_d  = RDATA;
            end
          end
        end
        // A partial byte only ever touches shift/cnt, so START/STOP mid-byte discards it
        PTR, WDATA: begin
          if (rx_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
          end else if (rx_fall) begin
            sda_oe_d = 1'b1;
            cnt_d    = 4'd0;
            if (state_q == PTR) begin
              ptr_d   = shift_q[PTR_W-1:0];
              state_d = PTR_ACK;
            end else begin
              regs_d[ptr_q] = shift_q;
              wr_pulse_d    = 1'b1;
              wr_idx_d      = ptr_q;
              ptr_d         = ptr_q + PTR_W'(1);
              state_d       = WDATA_ACK;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = WDATA;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + PTR_W'(1);
              cnt_d    = 4'd0;
              state_d  = RDATA_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        // cnt=1 records that the controller acknowledged and wants another byte
        RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              cnt_d = 4'd1;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            shift_d  = regs_q[ptr_q];
            sda_oe_d = ~regs_q[ptr_q][7];
            cnt_d    = 4'd0;
            state_d  = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      scl_pipe_q <= 3'b111;
      sda_pipe_q <= 3'b111;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'd0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_idx_q   <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'd0;
    end else begin
      scl_pipe_q <= scl_pipe_d;
      sda_pipe_q <= sda_pipe_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      wr_pulse_q <= wr_pulse_d;
      wr_idx_q   <= wr_idx_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
    assign regs_out[8*g +: 8] = regs_q[g];
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_idx    = wr_idx_q;
  assign state_dbg = state_q;
  assign ptr_dbg   = ptr_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C controller with a pulled-up SDA line.
module tb_i2c_target;

  localparam int Q = 60;  // quarter SCL period in ns; clk period is 10 ns

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        scl = 1'b1;
  logic        sda_drv = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic [31:0] regs_out;
  logic        wr_pulse;
  logic [1:0]  wr_idx;
  logic        busy;
  logic [3:0]  state_dbg;
  logic [1:0]  ptr_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int oe_cnt   = 0;
  int busy_cnt = 0;
  logic [1:0] wr_log[$];

  assign sda_line = sda_oe ? 1'b0 : sda_drv;

  i2c_target #(.I2C_ADDR(7'h50), .NREGS(4), .PTR_W(2)) dut (
    .clk(clk), .resetb(resetb), .scl_in(scl), .sda_in(sda_line),
    .sda_oe(sda_oe), .regs_out(regs_out), .wr_pulse(wr_pulse), .wr_idx(wr_idx),
    .busy(busy), .state_dbg(state_dbg), .ptr_dbg(ptr_dbg)
  );

  // clock/reset: posedges at 5,15,...; all bench stimulus lands on negedges
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_pulse) wr_log.push_back(wr_idx);
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic i2c_start();
    sda_drv = 1'b1; #Q;
    scl = 1'b1;     #Q;
    sda_drv = 1'b0; #Q;
    scl = 1'b0;     #Q;
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; #Q;
    scl = 1'b1;     #Q;
    sda_drv = 1'b1; #Q;
  endtask

  task automatic bit_out(input logic b);
    sda_drv = b; #Q;
    scl = 1'b1;  #(2*Q);
    scl = 1'b0;  #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    sda_drv = 1'b1; #Q;
    scl = 1'b1;     #Q;
    ack = ~sda_line; #Q;
    scl = 1'b0;     #Q;
  endtask

  task automatic read_byte(input logic give_ack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = 1'b1; #Q;
      scl = 1'b1;     #Q;
      d[i] = sda_line; #Q;
      scl = 1'b0;     #Q;
    end
    bit_out(~give_ack);
    sda_drv = 1'b1;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    #20;
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    n_checks++; if (regs_out !== 32'h0) begin n_fail++; $display("FAIL reset_regs: got %h want 00000000", regs_out); end
    n_checks++; if (busy !== 1'b0 || wr_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_busy_wr: got busy=%b wr=%b want 0 0", busy, wr_pulse); end
    n_checks++; if (state_dbg !== 4'd0 || ptr_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state_ptr: got %0d/%0d want 0/0", state_dbg, ptr_dbg); end
    resetb = 1'b1;
    #40;
  endtask

  task automatic test_write();
    logic [7:0] bytes [4];
    logic ack;
    int base;
    bytes = '{8'hA0, 8'h01, 8'hA5, 8'h3C};
    base = wr_log.size();
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes[i], ack);
      n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL write_ack byte %0d: got %b want 1", i, ack); end
    end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b want 1", busy); end
    i2c_stop();
    #Q;
    n_checks++; if (regs_out !== 32'h003C_A500) begin n_fail++; $display("FAIL write_regs: got %h want 003ca500", regs_out); end
    n_checks++; if (wr_log.size() !== base + 2) begin n_fail++; $display("FAIL write_pulses: got %0d want 2", wr_log.size() - base); end
    else begin
      n_checks++; if (wr_log[base] !== 2'd1 || wr_log[base+1] !== 2'd2) begin n_fail++; $display("FAIL write_idx: got %0d,%0d want 1,2", wr_log[base], wr_log[base+1]); end
    end
    n_checks++; if (ptr_dbg !== 2'd3) begin n_fail++; $display("FAIL write_ptr: got %0d want 3", ptr_dbg); end
    n_checks++; if (busy !== 1'b0 || state_dbg !== 4'd0) begin n_fail++; $display("FAIL write_stop: got busy=%b state=%0d want 0 0", busy, state_dbg); end
  endtask

  task automatic test_wrap();
    logic [7:0] bytes [4];
    logic ack;
    int base;
    bytes = '{8'hA0, 8'h03, 8'h11, 8'h22};
    base = wr_log.size();
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes[i], ack);
      n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wrap_ack byte %0d: got %b want 1", i, ack); end
    end
    i2c_stop();
    #Q;
    n_checks++; if (regs_out !== 32'h113C_A522) begin n_fail++; $display("FAIL wrap_regs: got %h want 113ca522", regs_out); end
    n_checks++; if (wr_log.size() !== base + 2) begin n_fail++; $display("FAIL wrap_pulses: got %0d want 2", wr_log.size() - base); end
    else begin
      n_checks++; if (wr_log[base] !== 2'd3 || wr_log[base+1] !== 2'd0) begin n_fail++; $display("FAIL wrap_idx: got %0d,%0d want 3,0", wr_log[base], wr_log[base+1]); end
    end
    n_checks++; if (ptr_dbg !== 2'd1) begin n_fail++; $display("FAIL wrap_ptr: got %0d want 1", ptr_dbg); end
  endtask

  task automatic test_read_rstart();
    logic [7:0] exp_b [3];
    logic [7:0] d;
    logic ack;
    exp_b = '{8'hA5, 8'h3C, 8'h11};
    i2c_start();
    write_byte(8'hA0, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL read_addr_w_ack: got %b want 1", ack); end
    write_byte(8'h01, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL read_ptr_ack: got %b want 1", ack); end
    i2c_start();
    write_byte(8'hA1, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL read_addr_r_ack: got %b want 1", ack); end
    for (int i = 0; i < 3; i++) begin
      read_byte(i < 2, d);
      n_checks++; if (d !== exp_b[i]) begin n_fail++; $display("FAIL read_data byte %0d: got %h want %h", i, d, exp_b[i]); end
    end
    n_checks++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL read_nack_exit: got oe=%b busy=%b want 0 0", sda_oe, busy); end
    n_checks++; if (state_dbg !== 4'd9) begin n_fail++; $display("FAIL read_nack_state: got %0d want 9", state_dbg); end
    n_checks++; if (ptr_dbg !== 2'd0) begin n_fail++; $display("FAIL read_ptr: got %0d want 0", ptr_dbg); end
    i2c_stop();
    #Q;
  endtask

  task automatic test_wrong_addr();
    logic ack;
    int oe0, busy0, base;
    oe0 = oe_cnt; busy0 = busy_cnt; base = wr_log.size();
    i2c_start();
    write_byte(8'hA2, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_ack: got %b want 0", ack); end
    write_byte(8'h55, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wrong_data_ack: got %b want 0", ack); end
    i2c_stop();
    #Q;
    n_checks++; if (oe_cnt !== oe0 || busy_cnt !== busy0) begin n_fail++; $display("FAIL wrong_addr_drive: got oe_cycles=%0d busy_cycles=%0d want 0 0", oe_cnt - oe0, busy_cnt - busy0); end
    n_checks++; if (regs_out !== 32'h113C_A522 || wr_log.size() !== base) begin n_fail++; $display("FAIL wrong_addr_regs: got %h pulses=%0d want 113ca522 0", regs_out, wr_log.size() - base); end
  endtask

  task automatic test_abort();
    logic ack;
    logic [3:0] part;
    int base;
    part = 4'b1011;
    base = wr_log.size();
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h00, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL abort_ptr_ack: got %b want 1", ack); end
    for (int i = 3; i >= 0; i--) bit_out(part[i]);
    i2c_stop();
    #Q;
    n_checks++; if (wr_log.size() !== base) begin n_fail++; $display("FAIL abort_pulse: got %0d want 0", wr_log.size() - base); end
    n_checks++; if (regs_out !== 32'h113C_A522) begin n_fail++; $display("FAIL abort_regs: got %h want 113ca522", regs_out); end
    n_checks++; if (state_dbg !== 4'd0 || sda_oe !== 1'b0 || ptr_dbg !== 2'd0) begin n_fail++; $display("FAIL abort_state: got state=%0d oe=%b ptr=%0d want 0 0 0", state_dbg, sda_oe, ptr_dbg); end
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    int base;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h00, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rst_read_drive: got %b want 1", sda_oe); end
    resetb = 1'b0;
    #1;
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_async_oe: got %b want 0", sda_oe); end
    n_checks++; if (regs_out !== 32'h0 || state_dbg !== 4'd0) begin n_fail++; $display("FAIL rst_async_regs: got %h state=%0d want 00000000 0", regs_out, state_dbg); end
    #19;
    resetb = 1'b1;
    #Q;
    base = wr_log.size();
    i2c_start();
    write_byte(8'hA0, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rst_recover_ack: got %b want 1", ack); end
    write_byte(8'h02, ack);
    write_byte(8'h77, ack);
    i2c_stop();
    #Q;
    n_checks++; if (regs_out !== 32'h0077_0000) begin n_fail++; $display("FAIL rst_recover_regs: got %h want 00770000", regs_out); end
    n_checks++; if (wr_log.size() !== base + 1) begin n_fail++; $display("FAIL rst_recover_pulse: got %0d want 1", wr_log.size() - base); end
    else begin
      n_checks++; if (wr_log[base] !== 2'd2) begin n_fail++; $display("FAIL rst_recover_idx: got %0d want 2", wr_log[base]); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrap();
    test_read_rstart();
    test_wrong_addr();
    test_abort();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
